// File: rtl/alu_div.sv
// Iterative 32-bit divider for DIV/DIVU/REM/REMU: restoring division, one quotient bit per clock.
// Divide-by-zero and signed overflow skip the iteration and resolve in a single cycle.
module alu_div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [2:0]  funct3,
  output logic        busy,
  output logic        valid,
  output logic [31:0] div_out
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic [31:0] out_q, out_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic        selr_q, selr_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;

  logic        signed_op;
  logic        div_zero;
  logic        ovf;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] shifted;
  logic [32:0] trial;
  logic        step_ok;
  logic [32:0] rem_step;
  logic [31:0] quo_step;
  logic [31:0] fin_q;
  logic [31:0] fin_r;
  logic        f3_unused;

  // funct3[2] is the decoder's concern; the partial remainder MSB is always 0 between iterations.
  assign f3_unused = ^{funct3[2], rem_q[32]};

  assign signed_op = ~funct3[0];
  assign div_zero  = (in_b == 32'd0);
  assign ovf       = signed_op && (in_a == 32'h8000_0000) && (in_b == 32'hFFFF_FFFF);
  assign abs_a     = (signed_op && in_a[31]) ? (32'd0 - in_a) : in_a;
  assign abs_b     = (signed_op && in_b[31]) ? (32'd0 - in_b) : in_b;

  assign shifted  = {rem_q[31:0], quo_q[31]};
  assign trial    = shifted - {1'b0, dvsr_q};
  assign step_ok  = ~trial[32];
  assign rem_step = step_ok ? trial : shifted;
  assign quo_step = {quo_q[30:0], step_ok};
  assign fin_q    = negq_q ? (32'd0 - quo_step) : quo_step;
  assign fin_r    = negr_q ? (32'd0 - rem_step[31:0]) : rem_step[31:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    out_d   = out_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    selr_d  = selr_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          selr_d = funct3[1];
          if (div_zero || ovf) begin
            state_d = DONE;
            valid_d = 1'b1;
            if (funct3[1])
              out_d = div_zero ? in_a : 32'd0;
            else
              out_d = div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
          end else begin
            state_d = CALC;
            cnt_d   = 5'd31;
            rem_d   = 33'd0;
            quo_d   = abs_a;
            dvsr_d  = abs_b;
            negq_d  = signed_op && (in_a[31] ^ in_b[31]);
            negr_d  = signed_op && in_a[31];
          end
        end
      end
      CALC: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          state_d = DONE;
          valid_d = 1'b1;
          cnt_d   = 5'd0;
          out_d   = selr_q ? fin_r : fin_q;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      rem_q   <= 33'd0;
      quo_q   <= 32'd0;
      dvsr_q  <= 32'd0;
      out_q   <= 32'd0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      selr_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      out_q   <= out_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      selr_q  <= selr_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign busy    = busy_q;
  assign valid   = valid_q;
  assign div_out = out_q;

endmodule

// File: tb/tb_alu_div.sv
// Directed-vector bench for alu_div: results, latency, single-cycle valid,
// start ignored while busy, and asynchronous reset abort.
module tb_alu_div;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  funct3;
  logic        busy;
  logic        valid;
  logic [31:0] div_out;

  int total;
  int bad;

  alu_div dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .in_a    (in_a),
    .in_b    (in_b),
    .funct3  (funct3),
    .busy    (busy),
    .valid   (valid),
    .div_out (div_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] F_DIV  = 3'b100;
  localparam logic [2:0] F_DIVU = 3'b101;
  localparam logic [2:0] F_REM  = 3'b110;
  localparam logic [2:0] F_REMU = 3'b111;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Issue one operation, wait for valid, check result, latency and handshake.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int k;
    logic busy_lost;
    logic [31:0] res;
    @(negedge clk);
    funct3 = f3;
    in_a   = a;
    in_b   = b;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    k = 0;
    busy_lost = 1'b0;
    while (!valid && k < 60) begin
      if (!busy) busy_lost = 1'b1;
      @(posedge clk);
      #1;
      k++;
    end
    res = div_out;
    chk({tag, "_lat"}, k, exp_lat);
    chk({tag, "_out"}, res, exp);
    chk({tag, "_busy"}, {31'd0, busy_lost | ~busy}, 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_vpulse"}, {31'd0, valid}, 32'd0);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    chk({tag, "_hold"}, div_out, exp);
    $display("op %-10s f3=%b a=%h b=%h -> %h (lat %0d)", tag, f3, a, b, res, k);
  endtask

  initial begin
    int pulses;
    logic [31:0] seen;
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    in_a   = 32'd0;
    in_b   = 32'd0;
    funct3 = 3'b000;
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_out", div_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("divu_100_7", F_DIVU, 32'd100, 32'd7, 32'd14, 32);
    run_op("remu_100_7", F_REMU, 32'd100, 32'd7, 32'd2, 32);
    run_op("div_m7_2",   F_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32);
    run_op("rem_m7_2",   F_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32);
    run_op("divu_by0",   F_DIVU, 32'd123, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("remu_by0",   F_REMU, 32'd123, 32'd0, 32'd123, 0);
    run_op("div_by0",    F_DIV,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("rem_by0",    F_REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 0);
    run_op("div_ovf",    F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("rem_ovf",    F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
    run_op("divu_noovf", F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32);
    run_op("div_20_m3",  F_DIV,  32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 32);
    run_op("rem_20_m3",  F_REM,  32'd20, 32'hFFFF_FFFD, 32'd2, 32);
    run_op("divu_max_2", F_DIVU, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32);
    run_op("div_m1_2",   F_DIV,  32'hFFFF_FFFF, 32'd2, 32'd0, 32);
    run_op("remu_5_10",  F_REMU, 32'd5, 32'd10, 32'd5, 32);
    run_op("f3_001",     3'b001, 32'd100, 32'd7, 32'd14, 32);

    // Start re-asserted mid-calculation must be ignored.
    @(negedge clk);
    funct3 = F_DIVU;
    in_a   = 32'd100;
    in_b   = 32'd7;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    funct3 = F_REMU;
    in_a   = 32'd999;
    in_b   = 32'd3;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    pulses = 0;
    seen   = 32'hDEAD_BEEF;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        pulses++;
        seen = div_out;
      end
    end
    chk("ign_pulses", pulses, 32'd1);
    chk("ign_out", seen, 32'd14);
    chk("ign_idle", {31'd0, busy}, 32'd0);
    $display("op %-10s pulses=%0d result=%h", "ignore", pulses, seen);

    // Asynchronous reset in the middle of a calculation.
    @(negedge clk);
    funct3 = F_DIVU;
    in_a   = 32'd1000;
    in_b   = 32'd3;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (14) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_valid", {31'd0, valid}, 32'd0);
    chk("arst_out", div_out, 32'd0);
    $display("op %-10s busy=%b valid=%b out=%h", "arst", busy, valid, div_out);
    #1 rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (valid) pulses++;
    end
    chk("arst_nopulse", pulses, 32'd0);
    run_op("post_rst",   F_DIVU, 32'd1000, 32'd3, 32'd333, 32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_div.md
ALU_DIV -- requirements
Module: alu_div

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock, sole clock domain.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: start  in  1  request a division; sampled only in IDLE.
REQ-004 SHALL have ports: in_a  in  32  dividend; sampled with start.
REQ-005 SHALL have ports: in_b  in  32  divisor; sampled with start.
REQ-006 SHALL have ports: funct3  in  3  op; sampled with start. Encodings: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have ports: busy  out  1  high while the unit is not IDLE.
REQ-008 SHALL have ports: valid  out  1  single-cycle result strobe.
REQ-009 SHALL have ports: div_out  out  32  result; stable from valid until the next accepted start.
REQ-010 SHALL have no parameters; all widths are fixed at 32.

Function
REQ-011 SHALL implement FSM states IDLE, CALC and DONE.
REQ-012 IDLE SHALL move on a start edge: to DONE when the operation is a special case, otherwise to CALC; it SHALL stay in IDLE when start is low.
REQ-013 CALC SHALL run an iterative restoring division with 32 iterations, one per clock, tracked by a 5-bit counter loaded with 31 and decremented to 0; it SHALL go to DONE after the iteration at count 0.
REQ-014 DONE SHALL assert valid for exactly one cycle and then return to IDLE unconditionally.
REQ-015 start SHALL be ignored in CALC and DONE, with no effect on operands or the result.
REQ-016 Latency for the normal path SHALL be: start high at edge N gives valid high in the cycle after edge N+32. Result every 34 cycles minimum at back-to-back starts.
REQ-017 Latency for special cases SHALL be: valid high in the cycle after edge N.
REQ-018 For signed ops (funct3[0]=0), the iteration SHALL use the absolute values of in_a and in_b. For unsigned ops it SHALL use the raw values.
REQ-019 The partial remainder SHALL be 33 bits wide. Each iteration: shift {rem, quotient} left by 1, trial-subtract the divisor, and keep the result with quotient bit 1 only when it is non-negative.
REQ-020 For DIV, the quotient SHALL be negated when in_a[31] XOR in_b[31]. For REM, the remainder SHALL take the sign of in_a. Negation is two's complement, mod 2^32.
REQ-021 funct3[1] SHALL select the remainder (1) or the quotient (0) into div_out at the transition to DONE.
REQ-022 Divide by zero (in_b=0) SHALL be a special case: quotient 32'hFFFFFFFF for both DIV and DIVU, and remainder = in_a.
REQ-023 Signed overflow (DIV/REM with in_a=32'h80000000, in_b=32'hFFFFFFFF) SHALL be a special case: quotient 32'h80000000, remainder 0.
REQ-024 If funct3[2]=0 at start, the block SHALL still execute as the op given by funct3[1:0]; it is the decoder's job to gate start.

Reset
REQ-025 On rst_n low, the block SHALL immediately, with no clock required, set state IDLE, busy 0, valid 0, div_out 0, counter 0 and all internal operand/remainder registers 0.
REQ-026 On reset mid-CALC or in DONE, the block SHALL abort with no valid pulse and no partial result visible on div_out.
REQ-027 After rst_n deassertion, the first start SHALL be accepted on the first rising edge.

Verification
REQ-028 Scenario: DIVU in_a=100, in_b=7 -> div_out=14; valid exactly one cycle, 32 cycles after the start edge; busy high throughout.
REQ-029 Scenario: DIV in_a=-7 (32'hFFFFFFF9), in_b=2 -> div_out=32'hFFFFFFFD. Then REM with the same operands -> div_out=32'hFFFFFFFF.
REQ-030 Scenario: DIVU in_b=0, in_a=123 -> div_out=32'hFFFFFFFF one cycle after start. Then REMU with the same operands -> div_out=123.
REQ-031 Scenario: DIV in_a=32'h80000000, in_b=32'hFFFFFFFF -> div_out=32'h80000000. Then REM with the same operands -> div_out=0; each completes in 1 cycle.
REQ-032 Scenario: assert start again at cycle 10 of CALC with different operands -> ignored; the original result is unchanged and only one valid pulse occurs.
REQ-033 Scenario: pulse rst_n low at CALC cycle 15 with no clock edge -> busy=0, valid=0, div_out=0 immediately. A new start after release gives a correct result at full latency.
